// File: rtl/fa_v1_adder.sv
// fa_v1_adder
// Full adder built from identical ripple-carry cells, with an optional
// output register stage.
//   sum = a ^ b ^ cin, carry = majority(a, b, cin) per cell; over the whole
//   chain {carry, sum} = a + b + cin exactly (WIDTH+1 bits).
//
// Parameters
//   WIDTH    operand width in bits; cell i takes its carry-in from cell i-1
//   REG_OUT  0 = purely combinational outputs, 1 = outputs registered once
//
// Ports
//   sum    out  WIDTH  sum bits
//   carry  out  1      carry-out of the MSB cell
//   a      in   WIDTH  operand A
//   b      in   WIDTH  operand B
//   cin    in   1      carry-in to the LSB cell
//   clk    in   1      clock, only used when REG_OUT = 1
//   rst_n  in   1      asynchronous active-low reset, only used when REG_OUT = 1
//
// The adder ports come first so that 5-argument positional instances of the
// combinational cell bind without naming clk/rst_n.
module fa_v1_adder #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b0
) (
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             clk,
    input  logic             rst_n
);

    // c[i] is the carry into cell i; c[WIDTH] leaves the MSB cell.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    // Ripple-carry chain of identical full-adder cells, written at gate level
    // so X/Z inputs propagate exactly as the gates would propagate them.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    if (REG_OUT) begin : g_reg
        // Output stage: one cycle of latency, no handshake. Reset clears the
        // outputs immediately and drops any result captured before it.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum   <= '0;
                carry <= 1'b0;
            end else begin
                sum   <= s;
                carry <= c[WIDTH];
            end
        end
    end else begin : g_comb
        assign sum   = s;
        assign carry = c[WIDTH];

        // clk and rst_n have no function in the combinational build; they are
        // gathered here so they read as deliberately unused.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
    end

endmodule

// File: tb/tb_fa_v1_adder.sv
// tb_fa_v1_adder
// Directed bench for fa_v1_adder. Three instances are exercised:
//   dut_c1  WIDTH=1, REG_OUT=0  (the default cell)
//   dut_c8  WIDTH=8, REG_OUT=0  (ripple chain boundaries)
//   dut_r1  WIDTH=1, REG_OUT=1  (registered outputs and async reset)
// Expected values are written out by hand in the stimulus below.
module tb_fa_v1_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    // Combinational 1-bit instance
    logic a1, b1, cin1;
    logic sum1, carry1;

    // Combinational 8-bit instance
    logic [7:0] a8, b8;
    logic       cin8;
    logic [7:0] sum8;
    logic       carry8;

    // Registered 1-bit instance
    logic ar, br, cinr;
    logic sumr, carryr;

    int tests_run    = 0;
    int tests_failed = 0;

    fa_v1_adder dut_c1 (
        .sum   (sum1),
        .carry (carry1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .clk   (clk),
        .rst_n (rst_n)
    );

    fa_v1_adder #(.WIDTH(8)) dut_c8 (
        .sum   (sum8),
        .carry (carry8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .clk   (clk),
        .rst_n (rst_n)
    );

    fa_v1_adder #(.WIDTH(1), .REG_OUT(1'b1)) dut_r1 (
        .sum   (sumr),
        .carry (carryr),
        .a     (ar),
        .b     (br),
        .cin   (cinr),
        .clk   (clk),
        .rst_n (rst_n)
    );

    // Single comparison point: counts every check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives both combinational instances (the 1-bit one sees bit 0) and
    // lets the outputs settle.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                                 input logic cv);
        a8   = av;
        b8   = bv;
        cin8 = cv;
        a1   = av[0];
        b1   = bv[0];
        cin1 = cv;
        #20;
    endtask

    // Hand-computed {carry,sum} for the 1-bit sweep, indexed by {a,b,cin}.
    logic [1:0] sweep_exp [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    // Hand-computed 8-bit vectors: a, b, cin -> {carry, sum}.
    logic [7:0] vec_a   [5] = '{8'hFF, 8'hFF, 8'h00, 8'h5A, 8'h80};
    logic [7:0] vec_b   [5] = '{8'h01, 8'hFF, 8'h00, 8'h3C, 8'h80};
    logic       vec_cin [5] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
    logic [8:0] vec_exp [5] = '{9'h100, 9'h1FF, 9'h000, 9'h097, 9'h100};

    initial begin
        ar   = 1'b0;
        br   = 1'b0;
        cinr = 1'b0;

        // Directed 1-bit vectors
        applyStimulus(8'h00, 8'h00, 1'b0);
        checkOutput("v1_sum",   32'(sum1),   32'd0);
        checkOutput("v1_carry", 32'(carry1), 32'd0);
        applyStimulus(8'h00, 8'h01, 1'b0);
        checkOutput("v2_sum",   32'(sum1),   32'd1);
        checkOutput("v2_carry", 32'(carry1), 32'd0);
        applyStimulus(8'h01, 8'h00, 1'b1);
        checkOutput("v3_sum",   32'(sum1),   32'd0);
        checkOutput("v3_carry", 32'(carry1), 32'd1);
        applyStimulus(8'h01, 8'h01, 1'b1);
        checkOutput("v4_sum",   32'(sum1),   32'd1);
        checkOutput("v4_carry", 32'(carry1), 32'd1);

        // Full sweep of the 1-bit cell
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc = 3'(i);
            applyStimulus({7'd0, abc[2]}, {7'd0, abc[1]}, abc[0]);
            checkOutput($sformatf("sweep_%0d", i), 32'({carry1, sum1}),
                        32'(sweep_exp[i]));
        end

        // 8-bit ripple chain boundaries
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vec_a[i], vec_b[i], vec_cin[i]);
            checkOutput($sformatf("w8_vec%0d", i), 32'({carry8, sum8}),
                        32'(vec_exp[i]));
        end

        // Registered instance: load a value, then check async reset.
        @(negedge clk);
        ar = 1'b1; br = 1'b1; cinr = 1'b1;
        @(posedge clk); #1;
        checkOutput("reg_load", 32'({carryr, sumr}), 32'd3);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("reg_rst_async", 32'({carryr, sumr}), 32'd0);
        @(posedge clk); #1;
        checkOutput("reg_rst_hold", 32'({carryr, sumr}), 32'd0);

        // Release and check the first capture and the one-cycle latency.
        @(negedge clk);
        ar = 1'b1; br = 1'b1; cinr = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("reg_first", 32'({carryr, sumr}), 32'd2);
        ar = 1'b1; br = 1'b0; cinr = 1'b0;
        #2;
        checkOutput("reg_latency", 32'({carryr, sumr}), 32'd2);
        @(posedge clk); #1;
        checkOutput("reg_second", 32'({carryr, sumr}), 32'd1);

        // Reset dropped mid-cycle with a new operand in flight.
        @(negedge clk);
        ar = 1'b1; br = 1'b1; cinr = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reg_rst_mid", 32'({carryr, sumr}), 32'd0);
        @(posedge clk); #1;
        checkOutput("reg_rst_discard", 32'({carryr, sumr}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
